// File: rtl/mem_burst_master.sv
// mem_burst_master: issues a burst of single-beat read or write requests to a
// memory port using a valid/ready handshake, with an incrementing data pattern
// P(k) = seed + k*STRIDE. Optional read checking is compiled in with the
// macro MEM_BURST_MASTER_CHECK_EN; without it err_cnt/first_err_addr read 0.
module mem_burst_master #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR   = 8,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [ADDR-1:0]  start_addr,
  input  logic [ADDR:0]    num_loc,
  input  logic [WIDTH-1:0] seed,
  output logic [ADDR-1:0]  addr,
  output logic [WIDTH-1:0] wdata,
  output logic             wrbar,
  output logic             valid,
  input  logic             ready,
  input  logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [ADDR:0]    err_cnt,
  output logic [ADDR-1:0]  first_err_addr
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [ADDR:0]    MAX_BEATS = (ADDR+1)'(DEPTH);
  localparam logic [WIDTH-1:0] STEP      = WIDTH'(STRIDE);

  state_t           state;
  logic [ADDR:0]    beats_left;  // beats remaining after the one on the bus
  logic [WIDTH-1:0] pat;         // P(k) for the beat currently presented
  logic             wr_mode;
  logic             accept;
  logic [ADDR:0]    beats_req;

  assign accept    = valid & ready;
  assign beats_req = (num_loc > MAX_BEATS) ? MAX_BEATS : num_loc;

  // Command FSM; all request outputs are registered and held until acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      wdata      <= '0;
      wrbar      <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      beats_left <= '0;
      pat        <= '0;
      wr_mode    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            wr_mode <= dir;
            pat     <= seed;
            if (beats_req == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= XFER;
              valid      <= 1'b1;
              addr       <= start_addr;
              wrbar      <= dir;
              wdata      <= dir ? seed : '0;
              beats_left <= beats_req - 1'b1;
            end
          end
        end
        XFER: begin
          if (accept) begin
            if (!wr_mode) begin
              rd_data  <= rdata;
              rd_valid <= 1'b1;
            end
            if (beats_left == '0) begin
              state <= DONE;
              done  <= 1'b1;
              valid <= 1'b0;
              addr  <= '0;
              wdata <= '0;
              wrbar <= 1'b0;
            end else begin
              // address wraps naturally at 2^ADDR
              beats_left <= beats_left - 1'b1;
              addr       <= addr + 1'b1;
              pat        <= pat + STEP;
              if (wr_mode) wdata <= pat + STEP;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_BURST_MASTER_CHECK_EN
  logic err_seen;

  // Read checker: counts mismatches against P(k), latches the first address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
    end else if (state == IDLE && start) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
    end else if (state == XFER && accept && !wr_mode && rdata != pat) begin
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (!err_seen) begin
        first_err_addr <= addr;
        err_seen       <= 1'b1;
      end
    end
  end
`else
  assign err_cnt        = '0;
  assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: a responder/model process on the falling edge
// predicts every output from the command list and the bench's memory image,
// plus literal checks per directed scenario.
module tb_mem_burst_master;
  localparam int STRIDE = 1;
`ifdef MEM_BURST_MASTER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 0, rst = 0, start = 0, dir = 0, ready = 0;
  logic [7:0]  start_addr = 0;
  logic [8:0]  num_loc = 0;
  logic [31:0] seed = 0, rdata = 0;
  logic [7:0]  addr, first_err_addr;
  logic [31:0] wdata, rd_data;
  logic        wrbar, valid, busy, done, rd_valid;
  logic [8:0]  err_cnt;

  mem_burst_master #(.WIDTH(32), .DEPTH(256), .ADDR(8), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .start_addr(start_addr),
    .num_loc(num_loc), .seed(seed), .addr(addr), .wdata(wdata), .wrbar(wrbar),
    .valid(valid), .ready(ready), .rdata(rdata), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  typedef struct {logic [7:0] a; logic [31:0] wd; logic wr; logic [31:0] p;} beat_t;
  beat_t       q[$];
  logic [31:0] mem [256];
  logic [7:0]  log_a [512];
  logic [31:0] log_w [512];
  int          acc_cnt = 0, done_cnt = 0, rdv_cnt = 0, bp = 0, wc = 0;
  bit          m_busy = 0, done_due = 0, rd_due = 0, m_fseen = 0;
  logic [31:0] rd_exp = 0;
  logic [8:0]  m_err = 0;
  logic [7:0]  m_ferr = 0;

  // Model + responder: check outputs, then decide the next edge's handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_addr", addr, 0);   chk("rst_rdv", rd_valid, 0); chk("rst_rdata", rd_data, 0);
      chk("rst_err", err_cnt, 0); chk("rst_ferr", first_err_addr, 0);
      q.delete(); m_busy = 0; done_due = 0; rd_due = 0; wc = 0;
      m_err = 0; m_ferr = 0; m_fseen = 0; ready = 0;
    end else begin
      bit ev, cmd;
      ev = (q.size() != 0);
      chk("valid", valid, ev);
      if (ev) begin
        chk("addr", addr, q[0].a); chk("wdata", wdata, q[0].wd); chk("wrbar", wrbar, q[0].wr);
      end else begin
        chk("idle_addr", addr, 0); chk("idle_wdata", wdata, 0); chk("idle_wrbar", wrbar, 0);
      end
      chk("busy", busy, m_busy);
      chk("done", done, done_due);
      if (done) done_cnt++;
      chk("rd_valid", rd_valid, rd_due);
      if (rd_due) chk("rd_data", rd_data, rd_exp);
      if (rd_valid) rdv_cnt++;
      chk("err_cnt", err_cnt, m_err);
      chk("first_err", first_err_addr, m_ferr);

      cmd = start && !m_busy;
      if (done_due) m_busy = 0;
      done_due = 0; rd_due = 0;
      if (ev) begin
        if (wc >= bp) begin
          beat_t b;
          ready = 1; wc = 0;
          b = q.pop_front();
          if (acc_cnt < 512) begin log_a[acc_cnt] = b.a; log_w[acc_cnt] = b.wd; end
          acc_cnt++;
          if (b.wr) mem[b.a] = b.wd;
          else begin
            rdata = mem[b.a]; rd_exp = mem[b.a]; rd_due = 1;
            if (CHK && mem[b.a] != b.p) begin
              if (m_err != 9'h1FF) m_err++;
              if (!m_fseen) begin m_ferr = b.a; m_fseen = 1; end
            end
          end
          if (q.size() == 0) done_due = 1;
        end else begin
          ready = 0; wc++;
        end
      end else ready = 0;
      if (cmd) begin
        int n;
        n = (num_loc > 256) ? 256 : int'(num_loc);
        m_busy = 1; wc = 0; m_err = 0; m_ferr = 0; m_fseen = 0;
        for (int k = 0; k < n; k++) begin
          beat_t b;
          b.a  = 8'(int'(start_addr) + k);
          b.p  = seed + 32'(k * STRIDE);
          b.wr = dir;
          b.wd = dir ? b.p : 32'h0;
          q.push_back(b);
        end
        if (n == 0) done_due = 1;
      end
    end
  end

  task automatic issue(input bit d, input logic [7:0] sa, input logic [8:0] n,
                       input logic [31:0] s, input int bpv);
    @(posedge clk); #1;
    bp = bpv; acc_cnt = 0; done_cnt = 0; rdv_cnt = 0;
    start = 1; dir = d; start_addr = sa; num_loc = n; seed = s;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) chk("timeout", done_cnt, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);

    // 32-beat write, no backpressure
    issue(1, 8'd0, 9'd32, 32'h100, 0); wait_done(100);
    chk("w32_cnt", acc_cnt, 32); chk("w32_done", done_cnt, 1);
    chk("w32_a0", log_a[0], 0);  chk("w32_w0", log_w[0], 32'h100);
    chk("w32_a31", log_a[31], 31); chk("w32_w31", log_w[31], 32'h11F);

    // 4-beat write, 3 wait cycles per beat
    issue(1, 8'd40, 9'd4, 32'h200, 3); wait_done(100);
    chk("bp_cnt", acc_cnt, 4); chk("bp_done", done_cnt, 1); chk("bp_w3", log_w[3], 32'h203);

    // wrapping read against preloaded pattern
    for (int k = 0; k < 4; k++) mem[8'(254 + k)] = 32'hA000 + 32'(k);
    issue(0, 8'd254, 9'd4, 32'hA000, 1); wait_done(100);
    chk("wr_a0", log_a[0], 254); chk("wr_a1", log_a[1], 255);
    chk("wr_a2", log_a[2], 0);   chk("wr_a3", log_a[3], 1);
    chk("wr_rdv", rdv_cnt, 4);   chk("wr_err", err_cnt, 0);

    // read of 8 with location 3 corrupted
    for (int k = 0; k < 8; k++) mem[k] = 32'h500 + 32'(k);
    mem[3] = mem[3] ^ 32'hFF;
    issue(0, 8'd0, 9'd8, 32'h500, 0); wait_done(100);
    chk("ck_err", err_cnt, CHK ? 1 : 0); chk("ck_ferr", first_err_addr, CHK ? 3 : 0);
    chk("ck_rdv", rdv_cnt, 8);

    // zero-length command
    issue(1, 8'd9, 9'd0, 32'h1, 0); wait_done(20);
    chk("z_cnt", acc_cnt, 0); chk("z_done", done_cnt, 1);

    // second start while busy is ignored
    issue(1, 8'd100, 9'd4, 32'h700, 1);
    @(posedge clk); #1;
    start = 1; dir = 0; start_addr = 8'd7; num_loc = 9'd8;
    @(posedge clk); #1 start = 0;
    wait_done(100);
    chk("ig_cnt", acc_cnt, 4); chk("ig_done", done_cnt, 1); chk("ig_rdv", rdv_cnt, 0);

    // num_loc above DEPTH clamps to 256
    issue(1, 8'd0, 9'd300, 32'h0, 0); wait_done(400);
    chk("cl_cnt", acc_cnt, 256); chk("cl_a255", log_a[255], 255);

    // reset in the middle of beat 5 of a 16-beat write
    issue(1, 8'd0, 9'd16, 32'h900, 2);
    for (int i = 0; i < 200 && !(valid && addr == 8'd5); i++) begin @(posedge clk); #1; end
    chk("rs_hit", addr, 5);
    @(posedge clk); #1;
    rst = 0; #1;
    chk("rs_valid", valid, 0); chk("rs_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; acc_cnt = 0;
    repeat (20) @(posedge clk);
    chk("rs_noreq", acc_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameter WIDTH, default 32: data width of the memory port.
REQ-002 Parameter DEPTH, default 256: number of memory locations.
REQ-003 Parameter ADDR, default 8: address width, with 2^ADDR >= DEPTH.
REQ-004 Parameter STRIDE, default 1: increment applied to the write/check data pattern per beat.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; 0 resets the block.
REQ-007 start  input  1  one-cycle command strobe.
REQ-008 dir  input  1  1 = write burst, 0 = read burst; sampled with start.
REQ-009 start_addr  input  ADDR  first location; sampled with start.
REQ-010 num_loc  input  ADDR+1  number of beats; sampled with start.
REQ-011 seed  input  WIDTH  pattern value for beat 0; sampled with start.
REQ-012 addr  output  ADDR  memory address.
REQ-013 wdata  output  WIDTH  memory write data.
REQ-014 wrbar  output  1  1 = write, 0 = read.
REQ-015 valid  output  1  request valid.
REQ-016 ready  input  1  responder accept; rdata is valid in the same cycle on reads.
REQ-017 rdata  input  WIDTH  memory read data.
REQ-018 busy  output  1  command in progress.
REQ-019 done  output  1  one-cycle pulse at burst completion.
REQ-020 rd_data  output  WIDTH  captured read beat.
REQ-021 rd_valid  output  1  one-cycle pulse per captured read beat.
REQ-022 err_cnt  output  ADDR+1  saturating count of read mismatches.
REQ-023 first_err_addr  output  ADDR  address of the first mismatch since start.

Function
REQ-024 FSM states: IDLE, XFER, DONE; IDLE->XFER on start with num_loc!=0; IDLE->DONE on start with num_loc==0; XFER->DONE when the last beat is accepted; DONE->IDLE unconditionally after 1 cycle.
REQ-025 The block ignores start while busy=1; busy=1 in XFER and DONE.
REQ-026 A beat is accepted on a rising edge with valid=1 and ready=1; until acceptance, addr, wdata, wrbar and valid hold stable.
REQ-027 valid rises the cycle after start; the next beat is presented the cycle after acceptance (1 beat/cycle peak); valid falls the cycle after the last acceptance.
REQ-028 Beat k uses addr = (start_addr + k) mod 2^ADDR, so bursts wrap from 2^ADDR-1 to 0.
REQ-029 num_loc greater than DEPTH is clamped to DEPTH beats.
REQ-030 Pattern for beat k is P(k) = (seed + k*STRIDE) mod 2^WIDTH, implemented as an accumulator.
REQ-031 Writes drive wdata=P(k) and wrbar=1; reads drive wrbar=0 and wdata=0.
REQ-032 On each accepted read beat, rd_data<=rdata and rd_valid pulses in the next cycle.
REQ-033 done pulses in the DONE state, exactly once per accepted command, including num_loc==0.
REQ-034 When idle, outputs are valid=0, wrbar=0, addr=0 and wdata=0.

Reset
REQ-035 rst=0 immediately forces IDLE and clears addr, wdata, wrbar, valid, busy, done, rd_data, rd_valid, err_cnt and first_err_addr, including mid-burst.
REQ-036 After rst deasserts, no request is issued until a new start.

Configuration
REQ-037 Macro MEM_BURST_MASTER_CHECK_EN compiles in read checking.
REQ-038 With the macro defined, each accepted read beat with rdata!=P(k) increments err_cnt, which saturates at 2^(ADDR+1)-1.
REQ-039 With the macro defined, the first such mismatch after start latches first_err_addr.
REQ-040 With the macro defined, a start clears err_cnt and first_err_addr.
REQ-041 Without the macro, err_cnt and first_err_addr remain ports and are tied to 0, and no compare logic is built.

Verification
REQ-042 Write: start, dir=1, start_addr=0, num_loc=32, seed=0x100, ready always 1 -> 32 consecutive beats at addr 0..31 with wdata 0x100..0x11F, then one done pulse.
REQ-043 Backpressure: write of 4 beats with ready low for 3 cycles per beat -> addr, wdata and valid stable while waiting; done appears after exactly 4 acceptances.
REQ-044 Wrap and read: read with start_addr=254, num_loc=4 against memory preloaded with the pattern -> addr 254, 255, 0, 1; 4 rd_valid pulses; err_cnt=0 with CHECK_EN.
REQ-045 Check: read of 8 beats with location 3 corrupted -> err_cnt=1 and first_err_addr=3 with CHECK_EN; both 0 without it.
REQ-046 Edge commands: start with num_loc=0 -> no valid, done 1 cycle later. A second start while busy -> ignored. num_loc=300 -> 256 beats.
REQ-047 Reset: rst=0 in the middle of beat 5 of a 16-beat write -> valid=0 and busy=0 immediately; no further requests after rst returns to 1.
